// File: rtl/clb_bist_pkg.sv
// ============================================================================
// clb_bist_pkg : shared types and constants for the CLB BIST sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package clb_bist_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_GOLD = 3'd1,
    RUN_SA1  = 3'd2,
    RUN_SA0  = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Vector is {m, cin, a}: two control bits above the pattern.
  localparam int VEC_EXTRA_W = 2;

  function automatic int vec_width(input int pat_w);
    return pat_w + VEC_EXTRA_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clb_bist_ctrl_if.sv
// ============================================================================
// clb_bist_ctrl_if : BIST sequencer <-> fault-injecting CLB datapath bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface clb_bist_ctrl_if #(
  parameter int PAT_W = 4
);
  logic [PAT_W-1:0] a;
  logic             cin;
  logic             m;
  logic             en;
  logic             sa1;
  logic             sa0;
  logic             s;
  logic             co;

  modport master (output a, cin, m, en, sa1, sa0, input s, co);
  modport slave  (input a, cin, m, en, sa1, sa0, output s, co);
endinterface

`default_nettype wire

// File: rtl/clb_bist_misr.sv
// ============================================================================
// clb_bist_misr : SIG_W-bit MISR with seed load, enable and 2-bit data input
// Rev 1.0
// ============================================================================
`default_nettype none

module clb_bist_misr
  import clb_bist_pkg::*;
#(
  parameter int SIG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       din,
  output logic [SIG_W-1:0] sig_nxt
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_nxt = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? SIG_W'(MISR_POLY) : {SIG_W{1'b0}})
            ^ {{(SIG_W-2){1'b0}}, din};
    sig_d = sig_q;
    if (load) begin
      sig_d = SIG_W'(MISR_SEED);
    end else if (en) begin
      sig_d = sig_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= SIG_W'(MISR_SEED);
    end else begin
      sig_q <= sig_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clb_bist_ctrl.sv
// ============================================================================
// clb_bist_ctrl : golden / stuck-at-1 / stuck-at-0 BIST sweep sequencer
// Optional first-fail capture: define CLB_BIST_FIRST_FAIL_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module clb_bist_ctrl
  import clb_bist_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int LAT   = 2,
  parameter int SIG_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  clb_bist_ctrl_if.master      dp,
  output logic                 busy,
  output logic                 done,
  output logic                 sa1_det,
  output logic                 sa0_det,
  output logic [SIG_W-1:0]     gold_sig,
  output logic [PAT_W+1:0]     first_fail_sa1,
  output logic [PAT_W+1:0]     first_fail_sa0
);

  localparam int VEC_W  = vec_width(PAT_W);
  localparam int HOLD   = LAT + 1;
  localparam int HCNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
  logic [SIG_W-1:0]   gold_sig_q, gold_sig_d;
  logic               sa1_det_q, sa1_det_d;
  logic               sa0_det_q, sa0_det_d;

  logic               in_run, sample, last, start_ok;
  logic [SIG_W-1:0]   sig_nxt;
  logic [PAT_W-1:0]   a_w;
  logic               cin_w, m_w, en_w, sa1_w, sa0_w;

  assign in_run   = (state_q == RUN_GOLD) || (state_q == RUN_SA1) || (state_q == RUN_SA0);
  assign sample   = in_run && (hcnt_q == HCNT_W'(HOLD - 1));
  assign last     = sample && (vec_q == {VEC_W{1'b1}});
  assign start_ok = (state_q == IDLE) && start && !abort;

  clb_bist_misr #(.SIG_W(SIG_W)) u_misr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok || (last && !abort)),
    .en      (sample && !abort),
    .din     ({dp.s, dp.co}),
    .sig_nxt (sig_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      hcnt_q     <= '0;
      gold_sig_q <= '0;
      sa1_det_q  <= 1'b0;
      sa0_det_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      hcnt_q     <= hcnt_d;
      gold_sig_q <= gold_sig_d;
      sa1_det_q  <= sa1_det_d;
      sa0_det_q  <= sa0_det_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start)  state_d = RUN_GOLD;
      RUN_GOLD: if (last)   state_d = RUN_SA1;
      RUN_SA1:  if (last)   state_d = RUN_SA0;
      RUN_SA0:  if (last)   state_d = DONE;
      DONE:                 state_d = IDLE;
      default:              state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Vector/hold counters and per-phase verdicts; vec wraps to 0 on phase end.
  always_comb begin
    vec_d      = vec_q;
    hcnt_d     = hcnt_q;
    gold_sig_d = gold_sig_q;
    sa1_det_d  = sa1_det_q;
    sa0_det_d  = sa0_det_q;
    if (start_ok) begin
      vec_d      = '0;
      hcnt_d     = '0;
      gold_sig_d = '0;
      sa1_det_d  = 1'b0;
      sa0_det_d  = 1'b0;
    end else if (abort) begin
      vec_d     = '0;
      hcnt_d    = '0;
      sa1_det_d = 1'b0;
      sa0_det_d = 1'b0;
    end else if (sample) begin
      hcnt_d = '0;
      vec_d  = vec_q + VEC_W'(1);
      if (last) begin
        case (state_q)
          RUN_GOLD: gold_sig_d = sig_nxt;
          RUN_SA1:  sa1_det_d  = (sig_nxt != gold_sig_q);
          RUN_SA0:  sa0_det_d  = (sig_nxt != gold_sig_q);
          default:  ;
        endcase
      end
    end else if (in_run) begin
      hcnt_d = hcnt_q + HCNT_W'(1);
    end
  end

  always_comb begin
    {m_w, cin_w, a_w} = '0;
    en_w  = 1'b0;
    sa1_w = 1'b0;
    sa0_w = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      RUN_GOLD: begin en_w = 1'b1; busy = 1'b1; {m_w, cin_w, a_w} = vec_q; end
      RUN_SA1:  begin en_w = 1'b1; busy = 1'b1; sa1_w = 1'b1; {m_w, cin_w, a_w} = vec_q; end
      RUN_SA0:  begin en_w = 1'b1; busy = 1'b1; sa0_w = 1'b1; {m_w, cin_w, a_w} = vec_q; end
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  assign dp.a     = a_w;
  assign dp.cin   = cin_w;
  assign dp.m     = m_w;
  assign dp.en    = en_w;
  assign dp.sa1   = sa1_w;
  assign dp.sa0   = sa0_w;
  assign gold_sig = gold_sig_q;
  assign sa1_det  = sa1_det_q;
  assign sa0_det  = sa0_det_q;

`ifdef CLB_BIST_FIRST_FAIL_EN
  localparam int N = 2 ** VEC_W;

  logic [1:0]       gold_mem_q [N];
  logic [1:0]       gold_mem_d [N];
  logic [VEC_W-1:0] ff_sa1_q, ff_sa1_d;
  logic [VEC_W-1:0] ff_sa0_q, ff_sa0_d;

  // All-ones doubles as "not yet found": only the final vector can set it.
  always_comb begin
    gold_mem_d = gold_mem_q;
    ff_sa1_d   = ff_sa1_q;
    ff_sa0_d   = ff_sa0_q;
    if (start_ok) begin
      ff_sa1_d = '1;
      ff_sa0_d = '1;
    end else if (sample && !abort) begin
      case (state_q)
        RUN_GOLD: gold_mem_d[vec_q] = {dp.s, dp.co};
        RUN_SA1:  if ((ff_sa1_q == '1) && ({dp.s, dp.co} != gold_mem_q[vec_q])) ff_sa1_d = vec_q;
        RUN_SA0:  if ((ff_sa0_q == '1) && ({dp.s, dp.co} != gold_mem_q[vec_q])) ff_sa0_d = vec_q;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) gold_mem_q[i] <= 2'b00;
      ff_sa1_q <= '1;
      ff_sa0_q <= '1;
    end else begin
      gold_mem_q <= gold_mem_d;
      ff_sa1_q   <= ff_sa1_d;
      ff_sa0_q   <= ff_sa0_d;
    end
  end

  assign first_fail_sa1 = ff_sa1_q;
  assign first_fail_sa0 = ff_sa0_q;
`else
  assign first_fail_sa1 = '1;
  assign first_fail_sa0 = '1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clb_bist_ctrl.sv
// ============================================================================
// tb_clb_bist_ctrl : directed self-checking bench for clb_bist_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clb_bist_ctrl;

  localparam int PAT_W = 4;
  localparam int LAT   = 2;
  localparam int SIG_W = 16;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, sa1_det, sa0_det;
  logic [15:0] gold_sig;
  logic [5:0]  ff1, ff0;
  logic [1:0]  p1 = 2'b00;
  logic [1:0]  p2 = 2'b00;
  int          mode   = 0;
  int          checks = 0;
  int          errors = 0;
  logic [5:0]  exp_ff1, exp_ff0;

  clb_bist_ctrl_if #(.PAT_W(PAT_W)) dp_if ();

  clb_bist_ctrl #(.PAT_W(PAT_W), .LAT(LAT), .SIG_W(SIG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .dp             (dp_if),
    .busy           (busy),
    .done           (done),
    .sa1_det        (sa1_det),
    .sa0_det        (sa0_det),
    .gold_sig       (gold_sig),
    .first_fail_sa1 (ff1),
    .first_fail_sa0 (ff0)
  );

  always #5 clk = ~clk;

  // Datapath model: mode 0 ignores injection, mode 1 forces a[1]=0 (sa1) / a[2]=1 (sa0).
  function automatic logic [1:0] dp_model(input int md, input logic [5:0] v, input logic f1, input logic f0);
    logic [3:0] ai;
    ai = v[3:0];
    if (md == 0) return {^ai, v[4] & v[5]};
    if (f1) ai[1] = 1'b0;
    if (f0) ai[2] = 1'b1;
    return {^ai ^ v[4], v[4] & v[5]};
  endfunction

  function automatic logic [15:0] exp_sig(input int md, input int phase);
    logic [15:0] sg;
    logic [1:0]  d;
    sg = 16'hFFFF;
    for (int v = 0; v < 64; v++) begin
      d  = dp_model(md, 6'(v), phase == 1, phase == 2);
      sg = {sg[14:0], 1'b0} ^ (sg[15] ? 16'h1021 : 16'h0000) ^ {14'b0, d};
    end
    return sg;
  endfunction

  // Two-stage pipeline gives the LAT=2 response delay.
  always @(posedge clk) begin
    p1 <= dp_if.en ? dp_model(mode, {dp_if.m, dp_if.cin, dp_if.a}, dp_if.sa1, dp_if.sa0) : 2'b00;
    p2 <= p1;
  end
  assign dp_if.s  = p2[1];
  assign dp_if.co = p2[0];

  // Launch a run and watch it for 600 cycles, counting busy cycles, done pulses and window violations.
  task automatic do_run(input int extra_start_at, output int busy_cycles, output int done_pulses, output int win_err);
    logic e_sa1, e_sa0, e_en;
    busy_cycles = 0; done_pulses = 0; win_err = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      e_sa1 = (c >= 192) && (c < 384);
      e_sa0 = (c >= 384) && (c < 576);
      e_en  = (c < 576);
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (c != 576) win_err++;
      end
      if (dp_if.sa1 !== e_sa1 || dp_if.sa0 !== e_sa0 || dp_if.en !== e_en) win_err++;
      if (dp_if.sa1 && dp_if.sa0) win_err++;
      if (c == extra_start_at)     start = 1'b1;
      if (c == extra_start_at + 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if ({busy, done, sa1_det, sa0_det} !== 4'b0) begin errors++; $display("FAIL reset_status: got %b expected 0000", {busy, done, sa1_det, sa0_det}); end
    checks++; if ({dp_if.a, dp_if.cin, dp_if.m, dp_if.en, dp_if.sa1, dp_if.sa0} !== 9'b0) begin errors++; $display("FAIL reset_datapath: got %b expected 0", {dp_if.a, dp_if.cin, dp_if.m, dp_if.en, dp_if.sa1, dp_if.sa0}); end
    checks++; if (gold_sig !== 16'h0000) begin errors++; $display("FAIL reset_gold_sig: got %h expected 0000", gold_sig); end
    checks++; if ({ff1, ff0} !== 12'hFFF) begin errors++; $display("FAIL reset_first_fail: got %h/%h expected 3f/3f", ff1, ff0); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_stub();
    int bc, dc, we;
    mode = 0;
    do_run(-10, bc, dc, we);
    checks++; if (bc != 576) begin errors++; $display("FAIL stub_busy_len: got %0d expected 576", bc); end
    checks++; if (dc != 1) begin errors++; $display("FAIL stub_done_pulses: got %0d expected 1", dc); end
    checks++; if (we != 0) begin errors++; $display("FAIL stub_windows: got %0d violations expected 0", we); end
    checks++; if (gold_sig !== exp_sig(0, 0)) begin errors++; $display("FAIL stub_gold_sig: got %h expected %h", gold_sig, exp_sig(0, 0)); end
    checks++; if ({sa1_det, sa0_det} !== 2'b00) begin errors++; $display("FAIL stub_det: got %b expected 00", {sa1_det, sa0_det}); end
    checks++; if ({ff1, ff0} !== 12'hFFF) begin errors++; $display("FAIL stub_first_fail: got %h/%h expected 3f/3f", ff1, ff0); end
  endtask

  task automatic test_real_faults();
    int bc, dc, we;
    mode = 1;
    do_run(-10, bc, dc, we);
    checks++; if (bc != 576 || dc != 1 || we != 0) begin errors++; $display("FAIL real_timing: got busy=%0d done=%0d viol=%0d expected 576/1/0", bc, dc, we); end
    checks++; if (gold_sig !== exp_sig(1, 0)) begin errors++; $display("FAIL real_gold_sig: got %h expected %h", gold_sig, exp_sig(1, 0)); end
    checks++; if (sa1_det !== (exp_sig(1, 1) != exp_sig(1, 0))) begin errors++; $display("FAIL real_sa1_det: got %b expected 1", sa1_det); end
    checks++; if (sa0_det !== (exp_sig(1, 2) != exp_sig(1, 0))) begin errors++; $display("FAIL real_sa0_det: got %b expected 1", sa0_det); end
    checks++; if (ff1 !== exp_ff1) begin errors++; $display("FAIL real_first_fail_sa1: got %h expected %h", ff1, exp_ff1); end
    checks++; if (ff0 !== exp_ff0) begin errors++; $display("FAIL real_first_fail_sa0: got %h expected %h", ff0, exp_ff0); end
  endtask

  task automatic test_abort();
    int bc, dc, we, dseen;
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (dp_if.sa1 !== 1'b1) begin errors++; $display("FAIL abort_pre_sa1: got %b expected 1", dp_if.sa1); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++; if ({busy, done, sa1_det, sa0_det} !== 4'b0) begin errors++; $display("FAIL abort_status: got %b expected 0000", {busy, done, sa1_det, sa0_det}); end
    checks++; if ({dp_if.a, dp_if.cin, dp_if.m, dp_if.en, dp_if.sa1, dp_if.sa0} !== 9'b0) begin errors++; $display("FAIL abort_datapath: got %b expected 0", {dp_if.a, dp_if.cin, dp_if.m, dp_if.en, dp_if.sa1, dp_if.sa0}); end
    dseen = 0;
    repeat (20) begin @(negedge clk); if (done || busy) dseen++; end
    checks++; if (dseen != 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dseen); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_same_cycle: got busy=%b expected 0", busy); end
    do_run(-10, bc, dc, we);
    checks++; if (bc != 576 || dc != 1 || we != 0) begin errors++; $display("FAIL abort_rerun: got busy=%0d done=%0d viol=%0d expected 576/1/0", bc, dc, we); end
    checks++; if (gold_sig !== exp_sig(1, 0)) begin errors++; $display("FAIL abort_rerun_gold: got %h expected %h", gold_sig, exp_sig(1, 0)); end
  endtask

  task automatic test_async_reset();
    int bc, dc, we;
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (450) @(negedge clk);
    checks++; if (dp_if.sa0 !== 1'b1) begin errors++; $display("FAIL areset_pre_sa0: got %b expected 1", dp_if.sa0); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({busy, done, sa1_det, sa0_det} !== 4'b0) begin errors++; $display("FAIL areset_status: got %b expected 0000", {busy, done, sa1_det, sa0_det}); end
    checks++; if ({dp_if.a, dp_if.cin, dp_if.m, dp_if.en, dp_if.sa1, dp_if.sa0} !== 9'b0) begin errors++; $display("FAIL areset_datapath: got %b expected 0", {dp_if.a, dp_if.cin, dp_if.m, dp_if.en, dp_if.sa1, dp_if.sa0}); end
    checks++; if (gold_sig !== 16'h0000 || {ff1, ff0} !== 12'hFFF) begin errors++; $display("FAIL areset_results: got %h %h/%h expected 0000 3f/3f", gold_sig, ff1, ff0); end
    @(negedge clk); rst = 1'b1;
    do_run(-10, bc, dc, we);
    checks++; if (bc != 576 || dc != 1) begin errors++; $display("FAIL areset_rerun: got busy=%0d done=%0d expected 576/1", bc, dc); end
    checks++; if (gold_sig !== exp_sig(1, 0)) begin errors++; $display("FAIL areset_rerun_gold: got %h expected %h", gold_sig, exp_sig(1, 0)); end
  endtask

  task automatic test_start_during_busy();
    int bc, dc, we;
    mode = 0;
    do_run(100, bc, dc, we);
    checks++; if (bc != 576) begin errors++; $display("FAIL busy_start_len: got %0d expected 576", bc); end
    checks++; if (dc != 1 || we != 0) begin errors++; $display("FAIL busy_start_done: got done=%0d viol=%0d expected 1/0", dc, we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_restart: got busy=%b expected 0", busy); end
  endtask

  initial begin
`ifdef CLB_BIST_FIRST_FAIL_EN
    exp_ff1 = 6'h02;
    exp_ff0 = 6'h00;
`else
    exp_ff1 = 6'h3F;
    exp_ff0 = 6'h3F;
`endif
    test_reset();
    test_stub();
    test_real_faults();
    test_abort();
    test_async_reset();
    test_start_during_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
